// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings for the memory port arbiter
package mem_port_arbiter_pkg;
   localparam int WORD_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_ACK   = 2'd3
   } state_t;

   localparam logic REQ_I = 1'b0;
   localparam logic REQ_D = 1'b1;
endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - grant select with data priority and fetch starvation guard
module mem_arb_pick
   import mem_port_arbiter_pkg::*;
#(
   parameter int STARVE = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_req_i,
   input  logic i_req_d,
   input  logic i_arb_en,
   output logic o_gnt_valid,
   output logic o_gnt_id
);
   localparam int CW = $clog2(STARVE + 1);

   logic [CW-1:0] r_starve;
   logic          w_starved;

   assign w_starved   = (r_starve == CW'(STARVE));
   assign o_gnt_valid = i_arb_en & (i_req_i | i_req_d);
   // Fetch wins a tie only once data has taken STARVE grants in a row over it.
   assign o_gnt_id    = (i_req_d && !(i_req_i && w_starved)) ? REQ_D : REQ_I;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_starve <= '0;
      end else if (o_gnt_valid) begin
         if (o_gnt_id == REQ_I) begin
            r_starve <= '0;
         end else if (i_req_i && !w_starved) begin
            r_starve <= r_starve + 1'b1;
         end
      end
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported memory between fetch and data requesters
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int WIDTH  = WORD_W,
   parameter int AWIDTH = 16,
   parameter int MEMLAT = 1,
   parameter int STARVE = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_i,
   input  logic [AWIDTH-1:0] addr_i,
   input  logic              req_d,
   input  logic              we_d,
   input  logic [AWIDTH-1:0] addr_d,
   input  logic [WIDTH-1:0]  wdata_d,
   output logic              ack_i,
   output logic              ack_d,
   output logic [WIDTH-1:0]  rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [AWIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0]  mem_wdata,
   input  logic [WIDTH-1:0]  mem_rdata,
   output logic              busy
);
   localparam int LAT_W = $clog2(MEMLAT + 1);

   state_t             r_state, w_next;
   logic [LAT_W-1:0]   r_lat;
   logic               r_id, r_we;
   logic [AWIDTH-1:0]  r_addr;
   logic [WIDTH-1:0]   r_wdata, r_rdata;
   logic               w_gnt_valid, w_gnt_id;

   mem_arb_pick #(.STARVE(STARVE)) u_pick (
      .i_clk       (clk),
      .i_rst       (reset),
      .i_req_i     (req_i),
      .i_req_d     (req_d),
      .i_arb_en    (r_state == ST_IDLE),
      .o_gnt_valid (w_gnt_valid),
      .o_gnt_id    (w_gnt_id)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (w_gnt_valid) w_next = ST_ISSUE;
         ST_ISSUE: w_next = (r_we || MEMLAT == 1) ? ST_ACK : ST_WAIT;
         ST_WAIT:  if (r_lat <= LAT_W'(1)) w_next = ST_ACK;
         ST_ACK:   w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_lat   <= '0;
         r_id    <= REQ_I;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == ST_IDLE && w_gnt_valid) begin
            r_id <= w_gnt_id;
            if (w_gnt_id == REQ_D) begin
               r_addr  <= addr_d;
               r_we    <= we_d;
               r_wdata <= wdata_d;
            end else begin
               r_addr <= addr_i;
               r_we   <= 1'b0;
            end
         end
         if (r_state == ST_ISSUE) begin
            r_lat <= LAT_W'(MEMLAT - 1);
         end else if (r_state == ST_WAIT) begin
            r_lat <= r_lat - 1'b1;
         end
         // Read data is captured on the edge entering ACK and is zero otherwise.
         if (w_next == ST_ACK) begin
            r_rdata <= r_we ? '0 : mem_rdata;
         end else begin
            r_rdata <= '0;
         end
      end
   end

   assign busy      = (r_state != ST_IDLE);
   assign mem_en    = (r_state == ST_ISSUE);
   assign mem_we    = mem_en & r_we;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign ack_i     = (r_state == ST_ACK) && (r_id == REQ_I);
   assign ack_d     = (r_state == ST_ACK) && (r_id == REQ_D);
   assign rdata     = r_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic        req_i_a = 0, req_d_a = 0, we_d_a = 0;
   logic [15:0] addr_i_a = 0, addr_d_a = 0, wdata_d_a = 0;
   logic        ack_i_a, ack_d_a, mem_en_a, mem_we_a, busy_a;
   logic [15:0] rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;

   logic        req_i_b = 0, req_d_b = 0, we_d_b = 0;
   logic [15:0] addr_i_b = 0, addr_d_b = 0, wdata_d_b = 0;
   logic        ack_i_b, ack_d_b, mem_en_b, mem_we_b, busy_b;
   logic [15:0] rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;

   mem_port_arbiter #(.WIDTH(16), .AWIDTH(16), .MEMLAT(1), .STARVE(4)) u_dut_a (
      .clk(clk), .reset(reset), .req_i(req_i_a), .addr_i(addr_i_a), .req_d(req_d_a),
      .we_d(we_d_a), .addr_d(addr_d_a), .wdata_d(wdata_d_a), .ack_i(ack_i_a), .ack_d(ack_d_a),
      .rdata(rdata_a), .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
      .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a), .busy(busy_a)
   );

   mem_port_arbiter #(.WIDTH(16), .AWIDTH(16), .MEMLAT(3), .STARVE(4)) u_dut_b (
      .clk(clk), .reset(reset), .req_i(req_i_b), .addr_i(addr_i_b), .req_d(req_d_b),
      .we_d(we_d_b), .addr_d(addr_d_b), .wdata_d(wdata_d_b), .ack_i(ack_i_b), .ack_d(ack_d_b),
      .rdata(rdata_b), .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
      .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b), .busy(busy_b)
   );

   logic [15:0] mem_a [256];
   logic [15:0] mem_b [256];
   logic        pl_en = 0;
   logic [7:0]  pl_addr = 0;
   logic [15:0] pl_data = 0;

   always @(posedge clk) begin
      if (pl_en) begin
         mem_a[pl_addr] <= pl_data;
         mem_b[pl_addr] <= pl_data;
      end else begin
         if (mem_en_a && mem_we_a) mem_a[mem_addr_a[7:0]] <= mem_wdata_a;
         if (mem_en_b && mem_we_b) mem_b[mem_addr_b[7:0]] <= mem_wdata_b;
      end
   end
   assign mem_rdata_a = mem_a[mem_addr_a[7:0]];
   assign mem_rdata_b = mem_b[mem_addr_b[7:0]];

   typedef struct packed {
      logic        id;
      logic [15:0] data;
   } exp_t;
   exp_t sb[$];

   int n_pass = 0;
   int n_total = 0;

   task automatic push_exp(input logic id, input logic [15:0] d);
      exp_t e;
      e.id = id;
      e.data = d;
      sb.push_back(e);
   endtask

   task automatic preload(input logic [7:0] a, input logic [15:0] d);
      @(negedge clk);
      pl_en = 1; pl_addr = a; pl_data = d;
      @(negedge clk);
      pl_en = 0;
   endtask

   task automatic wait_ack_a(input int exp_cyc, input string tag);
      int   c;
      logic seen;
      exp_t e;
      c = 0;
      seen = 0;
      while (!seen && c < exp_cyc + 4) begin
         @(negedge clk);
         c++;
         seen = ack_i_a | ack_d_a;
      end
      n_total++;
      if (!seen || c != exp_cyc)
         $display("FAIL %s latency: got %0d cycles, required %0d", tag, seen ? c : -1, exp_cyc);
      else n_pass++;
      if (seen) begin
         n_total++;
         if (ack_i_a && ack_d_a) $display("FAIL %s both_acks: ack_i=1 ack_d=1, required one", tag);
         else n_pass++;
         n_total++;
         if (sb.size() == 0) begin
            $display("FAIL %s unexpected_ack: ack_d=%0b with empty scoreboard", tag, ack_d_a);
         end else begin
            e = sb.pop_front();
            if ({ack_d_a, rdata_a} !== {e.id, e.data})
               $display("FAIL %s resp: got id=%0b rdata=%h, required id=%0b rdata=%h",
                        tag, ack_d_a, rdata_a, e.id, e.data);
            else n_pass++;
         end
      end
   endtask

   task automatic test_reset;
      preload(8'h10, 16'hBEEF);
      preload(8'h05, 16'h00A5);
      @(negedge clk);
      n_total++;
      if ({ack_i_a, ack_d_a, rdata_a, mem_en_a, mem_we_a, mem_addr_a, mem_wdata_a, busy_a} !== '0)
         $display("FAIL reset_a: outputs=%h, required 0",
                  {ack_i_a, ack_d_a, rdata_a, mem_en_a, mem_we_a, mem_addr_a, mem_wdata_a, busy_a});
      else n_pass++;
      n_total++;
      if ({ack_i_b, ack_d_b, rdata_b, mem_en_b, mem_we_b, mem_addr_b, mem_wdata_b, busy_b} !== '0)
         $display("FAIL reset_b: outputs=%h, required 0",
                  {ack_i_b, ack_d_b, rdata_b, mem_en_b, mem_we_b, mem_addr_b, mem_wdata_b, busy_b});
      else n_pass++;
      reset = 0;
   endtask

   task automatic test_fetch_read;
      @(negedge clk);
      req_i_a = 1; addr_i_a = 16'h0010;
      push_exp(REQ_I, 16'hBEEF);
      @(negedge clk);
      n_total++;
      if ({mem_en_a, mem_we_a, busy_a, ack_i_a, mem_addr_a} !== {4'b1010, 16'h0010})
         $display("FAIL fetch_issue: en/we/busy/ack/addr=%b/%h, required 1010/0010",
                  {mem_en_a, mem_we_a, busy_a, ack_i_a}, mem_addr_a);
      else n_pass++;
      wait_ack_a(1, "fetch_read");
      n_total++;
      if ({busy_a, mem_en_a} !== 2'b10) $display("FAIL fetch_ack_busy: busy/en=%b, required 10", {busy_a, mem_en_a});
      else n_pass++;
      req_i_a = 0;
      @(negedge clk);
      n_total++;
      if ({busy_a, ack_i_a} !== 2'b00) $display("FAIL fetch_idle: busy/ack=%b, required 00", {busy_a, ack_i_a});
      else n_pass++;
   endtask

   task automatic test_data_write;
      req_d_a = 1; we_d_a = 1; addr_d_a = 16'h0200; wdata_d_a = 16'h1234;
      push_exp(REQ_D, 16'h0000);
      @(negedge clk);
      n_total++;
      if ({mem_en_a, mem_we_a, mem_addr_a, mem_wdata_a} !== {2'b11, 16'h0200, 16'h1234})
         $display("FAIL write_issue: en/we=%b addr=%h wdata=%h, required 11/0200/1234",
                  {mem_en_a, mem_we_a}, mem_addr_a, mem_wdata_a);
      else n_pass++;
      addr_d_a = 16'hFFFF; wdata_d_a = 16'h0000; we_d_a = 0;
      wait_ack_a(1, "data_write");
      req_d_a = 0;
      @(negedge clk);
      req_d_a = 1; we_d_a = 0; addr_d_a = 16'h0200;
      push_exp(REQ_D, 16'h1234);
      wait_ack_a(2, "read_back");
      req_d_a = 0;
      @(negedge clk);
   endtask

   task automatic test_simultaneous;
      req_i_a = 1; addr_i_a = 16'h0010;
      req_d_a = 1; we_d_a = 0; addr_d_a = 16'h0200;
      push_exp(REQ_D, 16'h1234);
      push_exp(REQ_I, 16'hBEEF);
      wait_ack_a(2, "simul_data");
      req_d_a = 0;
      wait_ack_a(3, "simul_fetch");
      req_i_a = 0;
      @(negedge clk);
   endtask

   task automatic test_starvation;
      req_i_a = 1; addr_i_a = 16'h0010;
      req_d_a = 1; we_d_a = 0; addr_d_a = 16'h0200;
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 4; k++) push_exp(REQ_D, 16'h1234);
         push_exp(REQ_I, 16'hBEEF);
      end
      for (int k = 0; k < 10; k++) wait_ack_a((k == 0) ? 2 : 3, "starve");
      req_i_a = 0; req_d_a = 0;
      @(negedge clk);
   endtask

   task automatic test_read_latency;
      req_i_b = 1; addr_i_b = 16'h0005;
      @(negedge clk);
      n_total++;
      if ({mem_en_b, mem_addr_b} !== {1'b1, 16'h0005})
         $display("FAIL lat_issue: en=%b addr=%h, required 1/0005", mem_en_b, mem_addr_b);
      else n_pass++;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         n_total++;
         if ({mem_en_b, busy_b, ack_i_b, ack_d_b} !== 4'b0100)
            $display("FAIL lat_wait%0d: en/busy/ack_i/ack_d=%b, required 0100", k, {mem_en_b, busy_b, ack_i_b, ack_d_b});
         else n_pass++;
      end
      @(negedge clk);
      n_total++;
      if ({ack_i_b, ack_d_b, rdata_b} !== {2'b10, 16'h00A5})
         $display("FAIL lat_ack: ack_i/ack_d=%b rdata=%h, required 10/00a5", {ack_i_b, ack_d_b}, rdata_b);
      else n_pass++;
      req_i_b = 0;
      @(negedge clk);
      req_d_b = 1; we_d_b = 1; addr_d_b = 16'h0007; wdata_d_b = 16'h0055;
      @(negedge clk);
      @(negedge clk);
      n_total++;
      if ({ack_i_b, ack_d_b, rdata_b} !== {2'b01, 16'h0000})
         $display("FAIL lat_write_ack: ack_i/ack_d=%b rdata=%h, required 01/0000", {ack_i_b, ack_d_b}, rdata_b);
      else n_pass++;
      req_d_b = 0; we_d_b = 0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_read;
      int   c;
      logic seen;
      req_i_b = 1; addr_i_b = 16'h0005;
      @(negedge clk);
      @(negedge clk);
      #1 reset = 1;
      #1;
      n_total++;
      if ({ack_i_b, ack_d_b, rdata_b, mem_en_b, mem_we_b, mem_addr_b, mem_wdata_b, busy_b} !== '0)
         $display("FAIL reset_mid_read: outputs=%h, required 0",
                  {ack_i_b, ack_d_b, rdata_b, mem_en_b, mem_we_b, mem_addr_b, mem_wdata_b, busy_b});
      else n_pass++;
      req_i_b = 0;
      @(negedge clk);
      reset = 0;
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (ack_i_b || ack_d_b || busy_b) seen = 1;
      end
      n_total++;
      if (seen !== 1'b0) $display("FAIL reset_no_ack: activity=%b, required 0", seen);
      else n_pass++;
      req_i_b = 1; addr_i_b = 16'h0010;
      c = 0;
      seen = 0;
      while (!seen && c < 10) begin
         @(negedge clk);
         c++;
         seen = ack_i_b;
      end
      n_total++;
      if (!seen || c != 4 || rdata_b !== 16'hBEEF)
         $display("FAIL post_reset_read: cycles=%0d rdata=%h, required 4/beef", seen ? c : -1, rdata_b);
      else n_pass++;
      req_i_b = 0;
      @(negedge clk);
   endtask

   initial begin
      test_reset;
      test_fetch_read;
      test_data_write;
      test_simultaneous;
      test_starvation;
      test_read_latency;
      test_reset_mid_read;
      n_total++;
      if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d left, required 0", sb.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares one single-ported 16-bit main memory between the pipeline's instruction-fetch requester and its data requester (ld/st). It grants one requester at a time and drives the memory port. It waits out a fixed memory read latency, then returns data with a one-cycle acknowledge. Data requests have priority, and a starvation counter guarantees that instruction fetch always makes forward progress.

## Interface
- WIDTH, 16, data word width
- AWIDTH, 16, address width
- MEMLAT, 1, cycles from mem_en to valid mem_rdata (≥1)
- STARVE, 4, max consecutive data grants while fetch is pending (≥1)

- clk  in  1  clock; all state changes on posedge
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- req_i  in  1  fetch request; held high until ack_i
- addr_i  in  AWIDTH  fetch address
- req_d  in  1  data request; held high until ack_d
- we_d  in  1  data write (1) / read (0)
- addr_d  in  AWIDTH  data address
- wdata_d  in  WIDTH  data write value
- ack_i  out  1  one-cycle fetch completion pulse
- ack_d  out  1  one-cycle data completion pulse
- rdata  out  WIDTH  read data, valid while ack_i or ack_d is high
- mem_en  out  1  memory access strobe, one cycle per grant
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  AWIDTH  memory address
- mem_wdata  out  WIDTH  memory write data
- mem_rdata  in  WIDTH  memory read data
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, ISSUE, WAIT, ACK.
- **IDLE:** arbitrate on the sampled requests.
  - If neither request is high, stay in IDLE.
  - If one request is high, grant it.
  - If both are high, grant data, unless the starvation count equals STARVE; then grant fetch.
  - Any grant latches the requester id, address, write enable and write data, and moves to ISSUE.
- **ISSUE:** drive mem_en=1 with the latched mem_we, mem_addr and mem_wdata. For a write, or for MEMLAT=1, go to ACK; otherwise go to WAIT.
- **WAIT:** a countdown from MEMLAT-1 reaches 1, then moves to ACK. The counter is clog2(MEMLAT+1) bits wide.
- **ACK:** assert ack for the latched requester only. rdata holds mem_rdata captured at the edge leaving the last ISSUE/WAIT cycle (reads); it is 0 for writes. Always return to IDLE.
- Starvation count, saturating at STARVE:
  - increments on each data grant made while req_i is high;
  - clears on any fetch grant;
  - holds otherwise.
- Requesters drop req at the edge ending their ACK cycle. The arbiter never re-samples a request during ISSUE, WAIT or ACK.
- Address, write enable and write data changes on request inputs after the grant are ignored; the latched values are used.
- Outside ISSUE: mem_en=0, mem_we=0. mem_addr and mem_wdata hold their last values.

## Timing
- Request first seen high at the edge ending cycle 0 (in IDLE):
  - ISSUE in cycle 1;
  - read: ack in cycle 2+MEMLAT-1, i.e. cycle 2 for MEMLAT=1, and cycle MEMLAT+1 in general;
  - write: ack in cycle 2.
- mem_rdata is sampled at the end of cycle MEMLAT after ISSUE.
- The earliest next grant is sampled in the cycle after ACK. Back-to-back reads therefore take MEMLAT+2 cycles each.
- Reset, asserted at any time:
  - state goes to IDLE immediately;
  - all outputs go to 0: ack_i, ack_d, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy;
  - the starvation count and WAIT counter clear;
  - an in-flight access is dropped with no ack; a write already issued is not undone.
- Simultaneous requests are resolved only in IDLE. ack_i and ack_d are never high together.

## Structure
- Shared package holds the state encoding (IDLE=0, ISSUE=1, WAIT=2, ACK=3), the requester id constants (REQ_I=0, REQ_D=1) and the word width constant (16).
- One sub-module, mem_arb_pick, holds the combinational grant select plus the registered saturating starvation counter.
  - Inputs: req_i, req_d, arbitration enable (state==IDLE).
  - Outputs: grant valid, grant id.
- The FSM, latency counter and port registers stay in mem_port_arbiter.

## Test plan
- **Single fetch read.** MEMLAT=1, mem[0x0010]=0xBEEF, req_i with addr_i=0x0010.
  - Response: mem_en one cycle in cycle 1; ack_i in cycle 2 with rdata=0xBEEF; busy for cycles 1–2.
- **Data write.** req_d, we_d=1, addr_d=0x0200, wdata_d=0x1234.
  - Response: mem_we=1 with mem_en in cycle 1; ack_d in cycle 2; rdata=0; a subsequent read of 0x0200 returns 0x1234.
- **Simultaneous requests.** req_i and req_d raised in the same cycle.
  - Response: data is granted first; fetch is granted in the cycle after ack_d.
- **Starvation.** STARVE=4, req_i held high and req_d continuously re-raised.
  - Response: exactly 4 data grants, then a fetch grant; the counter is 0 after the fetch grant.
- **Read latency.** MEMLAT=3, read of 0x0005 holding 0x00A5.
  - Response: ack in cycle 4, rdata=0x00A5; no mem_en during WAIT.
- **Reset mid-read.** Reset pulsed during WAIT.
  - Response: all outputs 0 asynchronously; no ack follows; a new req_i after reset is served normally.
